// File: rtl/fifo_pkg.sv
// Shared types and constant helpers for the fifo_flow FIFO.
// Threshold helpers take plain integers so callers can mix parameter and register widths.
package fifo_pkg;

    typedef enum logic {
        FIFO_SHOWAHEAD = 1'b0,
        FIFO_REGOUT    = 1'b1
    } fifo_out_mode_e;

    function automatic fifo_out_mode_e out_mode(input int unsigned out_reg);
        return (out_reg != 0) ? FIFO_REGOUT : FIFO_SHOWAHEAD;
    endfunction

    function automatic logic lvl_ge(input int unsigned lvl, input int unsigned thr);
        return lvl >= thr;
    endfunction

    function automatic logic lvl_le(input int unsigned lvl, input int unsigned thr);
        return lvl <= thr;
    endfunction

    function automatic logic lvls_ok(input int unsigned aempty_lvl,
                                     input int unsigned afull_lvl,
                                     input int unsigned depth);
        return (aempty_lvl < afull_lvl) && (afull_lvl <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for fifo_flow: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATASIZE-1:0]   wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATASIZE-1:0]   rdata
);

    logic [DATASIZE-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flow.sv
// Single-clock FIFO with programmable almost-full/empty, fill level, synchronous flush,
// sticky overflow/underflow flags and an optional registered read port.
module fifo_flow
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AEMPTY_LVL = 2,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATASIZE-1:0]   wdata,
    input  logic                  winc,
    input  logic                  rinc,
    output logic [DATASIZE-1:0]   rdata,
    output logic                  rvalid,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  ovf,
    output logic                  udf
);

    localparam int unsigned         DEPTH   = 1 << ADDR_WIDTH;
    localparam fifo_out_mode_e      MODE    = out_mode(OUT_REG);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    if (!lvls_ok(AEMPTY_LVL, AFULL_LVL, DEPTH)) begin : g_lvl_check
        $error("fifo_flow: thresholds must satisfy AEMPTY_LVL < AFULL_LVL <= DEPTH");
    end

    logic [ADDR_WIDTH:0]  waddr_q, waddr_d;
    logic [ADDR_WIDTH:0]  raddr_q, raddr_d;
    logic [ADDR_WIDTH:0]  level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATASIZE-1:0]  rdata_q, rdata_d;
    logic [DATASIZE-1:0]  ram_rdata;
    logic                 full, empty;
    logic                 wr_ok, rd_ok;

    // Pointers carry one extra wrap bit: equal => empty, only the wrap bit differs => full.
    assign full  = (waddr_q[ADDR_WIDTH] != raddr_q[ADDR_WIDTH]) &&
                   (waddr_q[ADDR_WIDTH-1:0] == raddr_q[ADDR_WIDTH-1:0]);
    assign empty = (waddr_q == raddr_q);

    always_comb begin
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        wr_ok    = 1'b0;
        rd_ok    = 1'b0;

        if (flush) begin
            waddr_d = '0;
            raddr_d = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            // A simultaneous read frees a slot on a full FIFO, so the write still lands.
            wr_ok = winc & (~full | rinc);
            rd_ok = rinc & ~empty;

            if (wr_ok) begin
                waddr_d = waddr_q + PTR_ONE;
            end
            if (rd_ok) begin
                raddr_d  = raddr_q + PTR_ONE;
                rdata_d  = ram_rdata;
                rvalid_d = 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                level_d = level_q + PTR_ONE;
            end else if (rd_ok && !wr_ok) begin
                level_d = level_q - PTR_ONE;
            end

            ovf_d = ovf_q | (winc & full & ~rinc);
            udf_d = udf_q | (rinc & empty);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    fifo_ram #(
        .DATASIZE   (DATASIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (waddr_q[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (raddr_q[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    assign wfull  = full;
    assign rempty = empty;
    assign afull  = lvl_ge(32'(level_q), AFULL_LVL);
    assign aempty = lvl_le(32'(level_q), AEMPTY_LVL);
    assign level  = level_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;
    assign rdata  = (MODE == FIFO_REGOUT) ? rdata_q : ram_rdata;
    assign rvalid = (MODE == FIFO_REGOUT) ? rvalid_q : ~empty;

endmodule

// File: tb/tb_fifo_flow.sv
// Bench for fifo_flow: a show-ahead and a registered-output instance share stimulus and are
// checked every cycle against a queue-based model, plus directed scenarios with literal values.
module tb_fifo_flow;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;

    logic [7:0] s_rdata, r_rdata;
    logic       s_rvalid, r_rvalid, s_wfull, r_wfull, s_rempty, r_rempty;
    logic       s_afull, r_afull, s_aempty, r_aempty, s_ovf, r_ovf, s_udf, r_udf;
    logic [2:0] s_level, r_level;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    byte unsigned mq[$];
    bit           m_ovf, m_udf, m_rv;
    logic [7:0]   m_rreg;

    fifo_flow #(.DATASIZE(8), .ADDR_WIDTH(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .OUT_REG(0)) u_show (
        .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(s_rdata), .rvalid(s_rvalid), .wfull(s_wfull), .rempty(s_rempty),
        .afull(s_afull), .aempty(s_aempty), .level(s_level), .ovf(s_ovf), .udf(s_udf)
    );

    fifo_flow #(.DATASIZE(8), .ADDR_WIDTH(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .OUT_REG(1)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(r_rdata), .rvalid(r_rvalid), .wfull(r_wfull), .rempty(r_rempty),
        .afull(r_afull), .aempty(r_aempty), .level(r_level), .ovf(r_ovf), .udf(r_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ovf  = 0;
        m_udf  = 0;
        m_rv   = 0;
        m_rreg = 8'h00;
    endfunction

    // Queue-level view of one clock edge: decisions use the occupancy before the edge.
    function automatic void model_step(input bit w, input bit r, input logic [7:0] d, input bit f);
        int sz;
        bit wr_acc, rd_acc;
        if (f) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
            m_rv  = 0;
            return;
        end
        sz     = mq.size();
        wr_acc = w && (sz < 4 || r);
        rd_acc = r && (sz > 0);
        if (w && sz == 4 && !r) m_ovf = 1;
        if (r && sz == 0) m_udf = 1;
        m_rv = rd_acc;
        if (rd_acc) m_rreg = mq.pop_front();
        if (wr_acc) mq.push_back(d);
    endfunction

    always @(negedge clk) begin
        int sz;
        if (chk_en) begin
            sz = mq.size();
            check("s_level",  int'(s_level),  sz);
            check("s_wfull",  int'(s_wfull),  int'(sz == 4));
            check("s_rempty", int'(s_rempty), int'(sz == 0));
            check("s_afull",  int'(s_afull),  int'(sz >= 3));
            check("s_aempty", int'(s_aempty), int'(sz <= 1));
            check("s_ovf",    int'(s_ovf),    int'(m_ovf));
            check("s_udf",    int'(s_udf),    int'(m_udf));
            check("s_rvalid", int'(s_rvalid), int'(sz != 0));
            if (sz != 0) check("s_rdata", int'(s_rdata), int'(mq[0]));
            check("r_level",  int'(r_level),  sz);
            check("r_wfull",  int'(r_wfull),  int'(sz == 4));
            check("r_rempty", int'(r_rempty), int'(sz == 0));
            check("r_afull",  int'(r_afull),  int'(sz >= 3));
            check("r_aempty", int'(r_aempty), int'(sz <= 1));
            check("r_ovf",    int'(r_ovf),    int'(m_ovf));
            check("r_udf",    int'(r_udf),    int'(m_udf));
            check("r_rvalid", int'(r_rvalid), int'(m_rv));
            check("r_rdata",  int'(r_rdata),  int'(m_rreg));
        end
    end

    task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit f);
        winc  = w;
        rinc  = r;
        wdata = d;
        flush = f;
        @(posedge clk);
        if (rst) model_step(w, r, d, f);
        @(negedge clk);
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
    endtask

    // Asserts reset away from clock edges and returns on a falling edge with reset released.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp3 [4];
        rst   = 1'b1;
        flush = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;
        @(negedge clk);
        do_reset();
        chk_en = 1;

        // Reset mid-stream with sticky flags raised
        cyc(0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h60 + i), 0);
        check("t1_pre_ovf", int'(s_ovf), 1);
        check("t1_pre_udf", int'(s_udf), 1);
        do_reset();
        check("t1_level",  int'(s_level),  0);
        check("t1_rempty", int'(s_rempty), 1);
        check("t1_aempty", int'(s_aempty), 1);
        check("t1_wfull",  int'(s_wfull),  0);
        check("t1_ovf",    int'(r_ovf),    0);
        check("t1_udf",    int'(r_udf),    0);
        check("t1_rdata",  int'(r_rdata),  0);

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 8'(8'h11 * (i + 1)), 0);
            check("t2_level", int'(s_level), i + 1);
            check("t2_afull", int'(s_afull), int'(i >= 2));
            check("t2_wfull", int'(s_wfull), int'(i == 3));
        end
        cyc(1, 0, 8'h55, 0);
        check("t2_ovf",   int'(s_ovf),   1);
        check("t2_level", int'(s_level), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_show_rd", int'(s_rdata), 8'h11 * (i + 1));
            cyc(0, 1, 8'h00, 0);
            check("t2_reg_rd", int'(r_rdata),  8'h11 * (i + 1));
            check("t2_reg_rv", int'(r_rvalid), 1);
        end
        check("t2_rempty", int'(s_rempty), 1);

        // Full with simultaneous write and read
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'hA0 + i), 0);
        check("t3_show_head", int'(s_rdata), 8'hA0);
        cyc(1, 1, 8'hB0, 0);
        check("t3_reg_rd", int'(r_rdata), 8'hA0);
        check("t3_level",  int'(s_level), 4);
        check("t3_ovf",    int'(s_ovf),   0);
        exp3 = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
        for (int i = 0; i < 4; i++) begin
            check("t3_drain", int'(s_rdata), int'(exp3[i]));
            cyc(0, 1, 8'h00, 0);
        end

        // Empty with simultaneous write and read
        do_reset();
        cyc(1, 1, 8'h5A, 0);
        check("t4_udf",    int'(s_udf),    1);
        check("t4_level",  int'(s_level),  1);
        check("t4_show",   int'(s_rdata),  8'h5A);
        check("t4_reg_rv", int'(r_rvalid), 0);
        cyc(0, 1, 8'h00, 0);
        check("t4_reg_rd", int'(r_rdata), 8'h5A);

        // Interleaved traffic wrapping the pointers
        do_reset();
        cyc(1, 0, 8'h00, 0);
        for (int i = 1; i < 10; i++) begin
            check("t5_order", int'(s_rdata), i - 1);
            cyc(1, 1, 8'(i), 0);
            check("t5_level",  int'(s_level),  1);
            check("t5_wfull",  int'(s_wfull),  0);
            check("t5_rempty", int'(s_rempty), 0);
        end
        check("t5_last", int'(s_rdata), 8'h09);
        cyc(0, 1, 8'h00, 0);
        check("t5_empty", int'(s_rempty), 1);

        // Flush beats a concurrent write; registered data holds
        do_reset();
        cyc(0, 1, 8'h00, 0);
        for (int i = 1; i <= 3; i++) cyc(1, 0, 8'(8'hC0 + i), 0);
        cyc(0, 1, 8'h00, 0);
        cyc(1, 0, 8'hC4, 0);
        cyc(1, 0, 8'hEE, 1);
        check("t6_level",  int'(s_level),  0);
        check("t6_udf",    int'(s_udf),    0);
        check("t6_ovf",    int'(s_ovf),    0);
        check("t6_rv",     int'(r_rvalid), 0);
        check("t6_hold",   int'(r_rdata),  8'hC1);
        cyc(1, 0, 8'h77, 0);
        check("t6_new",    int'(s_rdata),  8'h77);
        check("t6_level1", int'(s_level),  1);

        // Randomised traffic with occasional flush and one mid-run reset
        for (int n = 0; n < 600; n++) begin
            bit w, r, f;
            w = ($urandom % 8) < ((n % 200 < 100) ? 6 : 3);
            r = ($urandom % 8) < ((n % 200 < 100) ? 3 : 6);
            f = ($urandom % 40) == 0;
            if (n == 350) do_reset();
            cyc(w, r, 8'($urandom), f);
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
